hack_run_ctrl: RTL and testbench

Load/run sequencer for the Hack-style miniCPU. Out of reset it holds the CPU in reset, takes a length-prefixed program image from a byte stream and writes it into instruction ROM. It then releases the CPU and controls execution: run, halt, single-step and a PC breakpoint. It sits between the host link (UART receiver) and the CPU/ROM pair, and drives the CPU's reset and clock-enable.

---
 rtl/hack_pkg.sv | 23 ++
 rtl/hack_byte_assembler.sv | 47 ++++
 rtl/hack_run_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hack_run_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack load/run sequencer.
// Holds the controller state encodings and the word/address widths.
package hack_pkg;

    localparam int ADDR_W_DEFAULT = 15;
    localparam int WORD_W         = 16;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DAT_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_HALTED = 3'd4,
        ST_RUN    = 3'd5,
        ST_STEP   = 3'd6
    } state_e;

    function automatic logic is_load(state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DAT_HI) || (s == ST_DAT_LO);
    endfunction

endpackage

// File: rtl/hack_byte_assembler.sv
// Pairs a high byte and a low byte into one 16-bit word.
// Ports: clock/reset, clear (forces the high-byte phase),
// byte_valid/byte_data in, word_valid pulse and word_data out.
module hack_byte_assembler
    import hack_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic       lo_phase_q, lo_phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        lo_phase_d = lo_phase_q;
        hi_d       = hi_q;
        if (clear) begin
            lo_phase_d = 1'b0;
        end else if (byte_valid) begin
            if (!lo_phase_q) begin
                hi_d = byte_data;
            end
            lo_phase_d = ~lo_phase_q;
        end
    end

    // The low byte is combined with the stored high byte in the
    // same cycle it arrives.
    assign word_valid = byte_valid & lo_phase_q & ~clear;
    assign word_data  = {hi_q, byte_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_phase_q <= 1'b0;
            hi_q       <= 8'd0;
        end else begin
            lo_phase_q <= lo_phase_d;
            hi_q       <= hi_d;
        end
    end

endmodule

// File: rtl/hack_run_ctrl.sv
// Load/run sequencer: loads a length-prefixed image into ROM, then runs,
// halts, single-steps and breaks the Hack CPU via cpu_reset/cpu_ce.
// Ports: clock/reset; rx_* byte stream in; rom_* write port out;
// cpu_reset/cpu_ce/pc_ to the CPU; bp_* breakpoint; cmd_* pulses;
// status (state encoding) and run_cycles (executed-cycle count) out.
module hack_run_ctrl
    import hack_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int ROM_DEPTH = 32768,
    parameter int CNT_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              cpu_ce,
    input  logic [ADDR_W-1:0] pc_,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              cmd_go,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    input  logic              cmd_load,
    output logic [2:0]        status,
    output logic [CNT_W-1:0]  run_cycles
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [WORD_W-1:0]   idx_q, idx_d;
    logic                skip_bp_q, skip_bp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0]   rom_wdata_q, rom_wdata_d;

    logic                load_st;
    logic                word_valid;
    logic [WORD_W-1:0]   word_data;
    logic                bp_hit;

    assign load_st = is_load(state_q);

    hack_byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (~load_st),
        .byte_valid (rx_valid & load_st),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        skip_bp_d   = skip_bp_q;
        cnt_d       = cnt_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        rx_ready    = 1'b0;
        cpu_reset   = 1'b0;
        cpu_ce      = 1'b0;
        bp_hit      = 1'b0;

        unique case (state_q)
            ST_LEN_HI: begin
                rx_ready  = 1'b1;
                cpu_reset = 1'b1;
                cpu_ce    = 1'b1;
                if (rx_valid) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                rx_ready  = 1'b1;
                cpu_reset = 1'b1;
                cpu_ce    = 1'b1;
                if (word_valid) begin
                    len_d   = word_data;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (word_data == '0) ? ST_HALTED
                                                : ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                rx_ready  = 1'b1;
                cpu_reset = 1'b1;
                cpu_ce    = 1'b1;
                if (rx_valid) state_d = ST_DAT_LO;
            end
            ST_DAT_LO: begin
                rx_ready  = 1'b1;
                cpu_reset = 1'b1;
                cpu_ce    = 1'b1;
                if (word_valid) begin
                    // Words past the ROM are swallowed, never wrapped.
                    if (32'(idx_q) < ROM_DEPTH) begin
                        rom_we_d    = 1'b1;
                        rom_addr_d  = ADDR_W'(idx_q);
                        rom_wdata_d = word_data;
                    end
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == len_q - 1'b1) ? ST_HALTED
                                                      : ST_DAT_HI;
                end
            end
            ST_HALTED: begin
                if (cmd_load) begin
                    state_d = ST_LEN_HI;
                end else if (cmd_halt) begin
                    state_d = ST_HALTED;
                end else if (cmd_step) begin
                    state_d   = ST_STEP;
                    skip_bp_d = 1'b1;
                end else if (cmd_go) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Gate the clock in the hit cycle so the instruction
                // at bp_addr does not execute.
                bp_hit    = bp_en & (pc_ == bp_addr) & ~skip_bp_q;
                cpu_ce    = ~bp_hit;
                skip_bp_d = 1'b0;
                if (cmd_load) begin
                    state_d = ST_LEN_HI;
                end else if (cmd_halt || bp_hit) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                cpu_ce  = 1'b1;
                state_d = cmd_load ? ST_LEN_HI : ST_HALTED;
            end
            default: begin
                state_d = ST_LEN_HI;
            end
        endcase

        if ((state_q == ST_RUN || state_q == ST_STEP) &&
            cpu_ce && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_LEN_HI;
            len_q       <= '0;
            idx_q       <= '0;
            skip_bp_q   <= 1'b0;
            cnt_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            skip_bp_q   <= skip_bp_d;
            cnt_q       <= cnt_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign status     = state_q;
    assign run_cycles = cnt_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Self-checking bench for hack_run_ctrl: directed image loads,
// a command table, breakpoint sequences and randomized run episodes.
module tb_hack_run_ctrl;

    localparam int AW = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          cpu_ce;
    logic [AW-1:0] pc_ = '0;
    logic          bp_en = 1'b0;
    logic [AW-1:0] bp_addr = '0;
    logic          cmd_go = 1'b0;
    logic          cmd_halt = 1'b0;
    logic          cmd_step = 1'b0;
    logic          cmd_load = 1'b0;
    logic [2:0]    status;
    logic [31:0]   run_cycles;

    hack_run_ctrl #(.ADDR_W(AW), .ROM_DEPTH(32768), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .cpu_ce(cpu_ce), .pc_(pc_),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .cmd_go(cmd_go), .cmd_halt(cmd_halt),
        .cmd_step(cmd_step), .cmd_load(cmd_load),
        .status(status), .run_cycles(run_cycles)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int ce_cnt = 0;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic          go, halt, step, load, en;
        logic [AW-1:0] pc;
        logic          exp_ce, exp_rst;
        logic [2:0]    exp_st;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (cpu_ce === 1'b1) ce_cnt++;
        if (rom_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("rom_we_unexpected", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rom_addr", 64'(rom_addr), 64'(e.addr));
                chk("rom_wdata", 64'(rom_wdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic g, input logic h,
                         input logic s, input logic l);
        cmd_go = g; cmd_halt = h; cmd_step = s; cmd_load = l;
        tick();
        cmd_go = 0; cmd_halt = 0; cmd_step = 0; cmd_load = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        #1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 64'd0, 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input logic [15:0] img[$], input int gmax);
        int n;
        wr_t e;
        n = img.size();
        send_byte(8'(n >> 8), $urandom_range(0, gmax));
        send_byte(8'(n), $urandom_range(0, gmax));
        for (int k = 0; k < n; k++) begin
            send_byte(img[k][15:8], $urandom_range(0, gmax));
            if (k < 32768) begin
                e.addr = k;
                e.data = img[k];
                exp_q.push_back(e);
            end
            send_byte(img[k][7:0], $urandom_range(0, gmax));
        end
    endtask

    initial begin
        logic [15:0] img[$];
        logic [2:0]  seq[$];
        int          c0, w0, exp_rc, delta, len, bp, en;
        logic        hit;
        wr_t         e;

        tbl[0]  = '{0, 0, 0, 0, 0, 15'd0, 0, 0, 3'd4};
        tbl[1]  = '{0, 0, 1, 0, 0, 15'd0, 0, 0, 3'd6};
        tbl[2]  = '{0, 0, 0, 0, 0, 15'd1, 1, 0, 3'd4};
        tbl[3]  = '{1, 0, 0, 0, 1, 15'd5, 0, 0, 3'd5};
        tbl[4]  = '{0, 0, 0, 0, 1, 15'd5, 1, 0, 3'd5};
        tbl[5]  = '{0, 0, 0, 0, 1, 15'd5, 0, 0, 3'd4};
        tbl[6]  = '{1, 0, 0, 0, 0, 15'd5, 0, 0, 3'd5};
        tbl[7]  = '{0, 0, 1, 0, 0, 15'd6, 1, 0, 3'd5};
        tbl[8]  = '{0, 1, 0, 0, 0, 15'd7, 1, 0, 3'd4};
        tbl[9]  = '{1, 1, 0, 0, 0, 15'd0, 0, 0, 3'd4};
        tbl[10] = '{1, 0, 1, 0, 0, 15'd0, 0, 0, 3'd6};
        tbl[11] = '{0, 0, 1, 1, 0, 15'd0, 1, 0, 3'd0};
        tbl[12] = '{1, 0, 0, 0, 0, 15'd0, 1, 1, 3'd0};
        tbl[13] = '{0, 1, 1, 0, 0, 15'd0, 1, 1, 3'd0};

        // Reset state
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_rom_we", 64'(rom_we), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_rom_wdata", 64'(rom_wdata), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_cpu_ce", 64'(cpu_ce), 64'd1);
        chk("rst_run_cycles", 64'(run_cycles), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);

        // Three-word image
        w0 = wr_cnt;
        img = '{16'h1234, 16'hABCD, 16'h0007};
        send_image(img, 0);
        tick();
        chk("img3_writes", 64'(wr_cnt - w0), 64'd3);
        chk("img3_pending", 64'(exp_q.size()), 64'd0);
        chk("img3_status", 64'(status), 64'd4);
        chk("img3_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("img3_cpu_ce", 64'(cpu_ce), 64'd0);

        // Empty image
        pulse(0, 0, 0, 1);
        chk("load_status", 64'(status), 64'd0);
        chk("load_cpu_reset", 64'(cpu_reset), 64'd1);
        w0 = wr_cnt;
        send_byte(8'h00, 0);
        chk("n0_status_lo", 64'(status), 64'd1);
        send_byte(8'h00, 0);
        chk("n0_status_end", 64'(status), 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("n0_rx_ready", 64'(rx_ready), 64'd0);
            tick();
        end
        chk("n0_writes", 64'(wr_cnt - w0), 64'd0);
        chk("n0_run_cycles", 64'(run_cycles), 64'd0);

        // Command table
        bp_addr = 15'd5;
        for (int i = 0; i < 14; i++) begin
            cmd_go = tbl[i].go; cmd_halt = tbl[i].halt;
            cmd_step = tbl[i].step; cmd_load = tbl[i].load;
            bp_en = tbl[i].en; pc_ = tbl[i].pc;
            #1;
            chk($sformatf("tbl%0d_ce", i), 64'(cpu_ce),
                64'(tbl[i].exp_ce));
            chk($sformatf("tbl%0d_rst", i), 64'(cpu_reset),
                64'(tbl[i].exp_rst));
            @(posedge clock);
            #1;
            cmd_go = 0; cmd_halt = 0; cmd_step = 0; cmd_load = 0;
            chk($sformatf("tbl%0d_st", i), 64'(status),
                64'(tbl[i].exp_st));
        end
        chk("tbl_run_cycles", 64'(run_cycles), 64'd5);
        bp_en = 1'b0;

        // Three single steps
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        c0 = ce_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 1, 0);
            tick();
            tick();
        end
        chk("step_ce_cycles", 64'(ce_cnt - c0), 64'd3);
        chk("step_run_cycles", 64'(run_cycles), 64'd3);

        // Breakpoint at 5
        pulse(0, 0, 0, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        bp_en = 1'b1;
        bp_addr = 15'd5;
        pc_ = 15'd0;
        pulse(1, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            pc_ = 15'(p);
            tick();
        end
        pc_ = 15'd5;
        #1;
        chk("bp_ce", 64'(cpu_ce), 64'd0);
        tick();
        chk("bp_status", 64'(status), 64'd4);
        chk("bp_run_cycles", 64'(run_cycles), 64'd5);

        // Resume from the breakpoint
        pulse(1, 0, 0, 0);
        #1;
        chk("resume_ce", 64'(cpu_ce), 64'd1);
        tick();
        chk("resume_status", 64'(status), 64'd5);
        pc_ = 15'd6;

        // Halt and load together: load wins
        pulse(0, 1, 0, 1);
        chk("hl_status", 64'(status), 64'd0);
        chk("hl_cpu_reset", 64'(cpu_reset), 64'd1);
        bp_en = 1'b0;

        // Randomized loads and run episodes
        for (int it = 0; it < 20; it++) begin
            img = {};
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) img.push_back(16'($urandom));
            send_image(img, 3);
            tick();
            chk("rnd_pending", 64'(exp_q.size()), 64'd0);
            chk("rnd_load_status", 64'(status), 64'd4);
            chk("rnd_load_rc", 64'(run_cycles), 64'd0);
            exp_rc = 0;
            for (int ep = 0; ep < 2; ep++) begin
                bp = $urandom_range(0, 7);
                en = $urandom_range(0, 1);
                len = $urandom_range(2, 10);
                seq = {};
                for (int j = 0; j < len; j++)
                    seq.push_back(3'($urandom_range(0, 7)));
                bp_en = en[0];
                bp_addr = 15'(bp);
                pc_ = 15'($urandom_range(0, 7));
                pulse(1, 0, 0, 0);
                // Executed count = index of first revisit of bp
                // after the first cycle, else the whole sequence.
                delta = len;
                for (int j = 0; j < len; j++) begin
                    pc_ = 15'(seq[j]);
                    hit = (en == 1) && (j >= 1) && (int'(seq[j]) == bp);
                    if (hit) begin
                        #1;
                        chk("rnd_bp_ce", 64'(cpu_ce), 64'd0);
                        delta = j;
                        tick();
                        break;
                    end
                    if (j == len - 1) cmd_halt = 1'b1;
                    tick();
                    cmd_halt = 1'b0;
                end
                exp_rc += delta;
                chk("rnd_run_status", 64'(status), 64'd4);
                chk("rnd_run_cycles", 64'(run_cycles), 64'(exp_rc));
            end
            bp_en = 1'b0;
            pulse(0, 0, 0, 1);
        end

        // Reset in the middle of word 2
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h40, 0);
            e.addr = k;
            e.data = {8'h40, 8'(k)};
            exp_q.push_back(e);
            send_byte(8'(k), 0);
        end
        send_byte(8'h77, 0);
        rx_data = 8'h88;
        rx_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rx_valid = 1'b0;
        chk("mid_status", 64'(status), 64'd0);
        chk("mid_rom_we", 64'(rom_we), 64'd0);
        chk("mid_rom_addr", 64'(rom_addr), 64'd0);
        tick();
        chk("mid_pending", 64'(exp_q.size()), 64'd0);

        // Image one word longer than the ROM
        w0 = wr_cnt;
        img = {};
        for (int k = 0; k < 32769; k++) img.push_back(16'(k ^ 16'h5A5A));
        send_image(img, 0);
        tick();
        chk("big_writes", 64'(wr_cnt - w0), 64'd32768);
        chk("big_pending", 64'(exp_q.size()), 64'd0);
        chk("big_status", 64'(status), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
